multicycle_controller: RTL

- Multi-cycle control FSM for the RISC-V core. It sequences one shared memory port and the ALU/register-file datapath through FETCH, DECODE, EXEC, MEM and WB per instruction.
- Decodes the 7-bit opcode held in the datapath instruction register, issues per-state strobes, and waits on a memory ready handshake.
- Halts on an illegal opcode or a memory timeout.

---
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle RISC-V
//               core with a shared memory port, a ready handshake and a
//               memory-wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_sel,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch_eval,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       instr_retired,
    output logic       illegal_op,
    output logic       timeout,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] C_OP_R   = 7'b0110011;
    localparam logic [6:0] C_OP_I   = 7'b0010011;
    localparam logic [6:0] C_OP_LW  = 7'b0000011;
    localparam logic [6:0] C_OP_SW  = 7'b0100011;
    localparam logic [6:0] C_OP_BR  = 7'b1100011;
    localparam logic [6:0] C_OP_LUI = 7'b0110111;

    localparam bit               C_TO_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic is_r, is_i, is_lw, is_sw, is_br, is_lui, is_legal;
    logic wait_expired;

    always_comb begin
        is_r     = (Opcode == C_OP_R);
        is_i     = (Opcode == C_OP_I);
        is_lw    = (Opcode == C_OP_LW);
        is_sw    = (Opcode == C_OP_SW);
        is_br    = (Opcode == C_OP_BR);
        is_lui   = (Opcode == C_OP_LUI);
        is_legal = is_r | is_i | is_lw | is_sw | is_br | is_lui;
    end

    // Ready in the last tolerated waiting cycle still completes the transfer.
    assign wait_expired = C_TO_EN && !mem_ready && (cnt_q == C_LAST);

    // The counter only survives a cycle that keeps waiting, so any entry into
    // FETCH or MEM starts from zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end else if (wait_expired) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_sel       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch_eval   = 1'b0;
        ALUSrc        = 1'b0;
        ALUOp         = 2'b00;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        instr_retired = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXEC: begin
                branch_eval   = is_br;
                instr_retired = is_br;
            end
            S_MEM: begin
                mem_req       = 1'b1;
                mem_sel       = 1'b1;
                mem_we        = is_sw;
                instr_retired = is_sw & mem_ready;
            end
            S_WB: begin
                RegWrite      = 1'b1;
                MemtoReg      = is_lw;
                instr_retired = 1'b1;
            end
            default: ;
        endcase

        if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            ALUSrc = is_lw | is_sw | is_i | is_lui;
            if (is_br)              ALUOp = 2'b01;
            else if (is_r || is_i)  ALUOp = 2'b10;
            else if (is_lui)        ALUOp = 2'b11;
            else                    ALUOp = 2'b00;
        end

        if (reset) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            branch_eval   = 1'b0;
            RegWrite      = 1'b0;
            instr_retired = 1'b0;
        end
    end

    assign illegal_op = illegal_q;
    assign timeout    = timeout_q;
    assign state_o    = state_q;

endmodule
`default_nettype wire
